// File: rtl/sprite_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_fetch_ctrl
//  Purpose  : Per-scanline sprite pattern fetch sequencer. Walks the 8 temp
//             sprite RAM slots, builds pattern addresses (vflip / 8x16),
//             fetches both bitplanes over a req/ack port, applies hflip and
//             shift-loads one 27-bit record per slot into the sprite shifters.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch_ctrl #(
    parameter int START_CYCLE    = 256,
    parameter int DEADLINE_CYCLE = 320
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_rendering,
    input  logic [8:0]  i_cycle,
    input  logic        i_obj_size,
    input  logic        i_spr_table,
    output logic [4:0]  o_tmp_addr,
    input  logic [7:0]  i_tmp_data,
    output logic        o_vram_req,
    output logic [12:0] o_vram_addr,
    input  logic        i_vram_ack,
    input  logic [7:0]  i_vram_data,
    output logic [3:0]  o_load,
    output logic [26:0] o_load_data,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_done
);

    localparam logic [8:0] c_START    = 9'(START_CYCLE);
    localparam logic [8:0] c_DEADLINE = 9'(DEADLINE_CYCLE);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_Y     = 4'd1,
        S_RD_TILE  = 4'd2,
        S_RD_ATTR  = 4'd3,
        S_RD_X     = 4'd4,
        S_FETCH_LO = 4'd5,
        S_GAP_LO   = 4'd6,
        S_FETCH_HI = 4'd7,
        S_GAP_HI   = 4'd8,
        S_LOAD     = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_slot;
    logic [7:0]  r_ydiff;
    logic [7:0]  r_tile;
    logic [7:0]  r_attr;
    logic [7:0]  r_x;
    logic [7:0]  r_pix_lo;
    logic [7:0]  r_pix_hi;
    logic        r_overrun;

    logic        w_busy;
    logic        w_start;
    logic        w_empty;
    logic        w_plane;
    logic [3:0]  w_row;
    logic [12:0] w_pat_addr;
    logic [7:0]  w_lo_px;
    logic [7:0]  w_hi_px;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_start = (r_state == S_IDLE) && i_rendering && (i_cycle == c_START);
    assign w_empty = (r_ydiff == 8'hFF);

    // State register; reset drops any request or load strobe at once.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; losing i_rendering while busy aborts to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_next = S_RD_Y;
            S_RD_Y:     w_next = S_RD_TILE;
            S_RD_TILE:  w_next = S_RD_ATTR;
            S_RD_ATTR:  w_next = S_RD_X;
            S_RD_X:     w_next = w_empty ? S_LOAD : S_FETCH_LO;
            S_FETCH_LO: if (i_vram_ack) w_next = S_GAP_LO;
            S_GAP_LO:   w_next = S_FETCH_HI;
            S_FETCH_HI: if (i_vram_ack) w_next = S_GAP_HI;
            S_GAP_HI:   w_next = S_LOAD;
            S_LOAD:     w_next = (r_slot == 3'd7) ? S_DONE : S_RD_Y;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (w_busy && !i_rendering) begin
            w_next = S_IDLE;
        end
    end

    // Slot counter and per-slot capture of temp RAM fields and pattern bytes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot   <= 3'd0;
            r_ydiff  <= 8'd0;
            r_tile   <= 8'd0;
            r_attr   <= 8'd0;
            r_x      <= 8'd0;
            r_pix_lo <= 8'd0;
            r_pix_hi <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE:     if (w_start) r_slot <= 3'd0;
                S_RD_Y:     r_ydiff <= i_tmp_data;
                S_RD_TILE:  r_tile  <= i_tmp_data;
                S_RD_ATTR:  r_attr  <= i_tmp_data;
                S_RD_X:     r_x     <= i_tmp_data;
                S_FETCH_LO: if (i_vram_ack) r_pix_lo <= i_vram_data;
                S_FETCH_HI: if (i_vram_ack) r_pix_hi <= i_vram_data;
                S_LOAD:     r_slot <= r_slot + 3'd1;
                default:    ;
            endcase
        end
    end

    // Sticky deadline flag, cleared when a new sequence starts.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_start) begin
            r_overrun <= 1'b0;
        end else if (w_busy && (i_cycle == c_DEADLINE)) begin
            r_overrun <= 1'b1;
        end
    end

    // Pattern row (with vertical flip) and address for the current plane.
    always_comb begin
        w_row = r_ydiff[3:0];
        if (r_attr[7]) begin
            w_row = i_obj_size ? (4'd15 - r_ydiff[3:0]) : (4'd7 - r_ydiff[3:0]);
        end
        w_plane = (r_state == S_FETCH_HI);
        if (i_obj_size) begin
            w_pat_addr = {r_tile[0], r_tile[7:1], w_row[3], w_plane, w_row[2:0]};
        end else begin
            w_pat_addr = {i_spr_table, r_tile, w_plane, w_row[2:0]};
        end
    end

    // Shifter emits bit 0 first, so un-flipped sprites are bit-reversed.
    always_comb begin
        w_lo_px = 8'd0;
        w_hi_px = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_lo_px[i] = r_attr[6] ? r_pix_lo[i] : r_pix_lo[7-i];
            w_hi_px[i] = r_attr[6] ? r_pix_hi[i] : r_pix_hi[7-i];
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        o_tmp_addr  = 5'd0;
        o_vram_req  = 1'b0;
        o_vram_addr = 13'd0;
        o_load      = 4'd0;
        o_load_data = 27'd0;
        o_done      = 1'b0;
        case (r_state)
            S_RD_Y:     o_tmp_addr = {r_slot, 2'd0};
            S_RD_TILE:  o_tmp_addr = {r_slot, 2'd1};
            S_RD_ATTR:  o_tmp_addr = {r_slot, 2'd2};
            S_RD_X:     o_tmp_addr = {r_slot, 2'd3};
            S_FETCH_LO,
            S_FETCH_HI: begin
                o_vram_req  = 1'b1;
                o_vram_addr = w_pat_addr;
            end
            S_LOAD: begin
                o_load = 4'b1111;
                if (!w_empty) begin
                    o_load_data = {w_lo_px, w_hi_px, r_x, r_attr[1:0], r_attr[5]};
                end
            end
            S_DONE:     o_done = 1'b1;
            default:    ;
        endcase
    end

    assign o_busy    = w_busy;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_fetch_ctrl
//  Purpose  : Self-checking bench for sprite_fetch_ctrl: directed vector
//             table, hand-written corner sequences and randomized scanlines
//             checked against a behavioural per-slot model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_rendering;
    logic [8:0]  i_cycle;
    logic        i_obj_size;
    logic        i_spr_table;
    logic [4:0]  o_tmp_addr;
    logic [7:0]  i_tmp_data;
    logic        o_vram_req;
    logic [12:0] o_vram_addr;
    logic        i_vram_ack;
    logic [7:0]  i_vram_data;
    logic [3:0]  o_load;
    logic [26:0] o_load_data;
    logic        o_busy;
    logic        o_overrun;
    logic        o_done;

    logic [7:0]  tmp  [0:31];
    logic [7:0]  vram [0:8191];

    assign i_tmp_data = tmp[o_tmp_addr];

    sprite_fetch_ctrl #(.START_CYCLE(256), .DEADLINE_CYCLE(320)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_rendering (i_rendering),
        .i_cycle     (i_cycle),
        .i_obj_size  (i_obj_size),
        .i_spr_table (i_spr_table),
        .o_tmp_addr  (o_tmp_addr),
        .i_tmp_data  (i_tmp_data),
        .o_vram_req  (o_vram_req),
        .o_vram_addr (o_vram_addr),
        .i_vram_ack  (i_vram_ack),
        .i_vram_data (i_vram_data),
        .o_load      (o_load),
        .o_load_data (o_load_data),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [26:0] act_loads[$];
    logic [26:0] exp_loads[$];
    int          act_addrs[$];
    int          exp_addrs[$];
    int          dq[$];
    int          dlo[8];
    int          dhi[8];
    int          done_cnt;
    int          wcnt;
    int          held;
    int          seq_len;
    bit          just_acked;

    typedef struct {
        logic [7:0]  y, tile, attr, x;
        logic        sz, tbl;
        logic [7:0]  lo, hi;
        logic [1:0]  nf;
        logic [12:0] alo;
        logic [7:0]  plo, phi, ex;
        logic [1:0]  pal;
        logic        prio;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rev8(input int b);
        int r = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) r += (1 << (7 - i));
        return r;
    endfunction

    // Expected record and lo-plane address of one slot, from the sprite rules.
    function automatic void model_slot(input int s, output logic [26:0] rec,
                                       output int addr, output bit full);
        int y    = int'(tmp[s*4]);
        int tile = int'(tmp[s*4+1]);
        int attr = int'(tmp[s*4+2]);
        int x    = int'(tmp[s*4+3]);
        int row, lo, hi;
        full = (y != 255);
        rec  = '0;
        addr = 0;
        if (!full) return;
        row = y % 16;
        if (((attr / 128) % 2) == 1) row = i_obj_size ? (15 - row) : (7 - (row % 8));
        if (i_obj_size) addr = (tile % 2) * 4096 + (tile / 2) * 32 + (row / 8) * 16 + (row % 8);
        else            addr = int'(i_spr_table) * 4096 + tile * 16 + (row % 8);
        lo = int'(vram[addr]);
        hi = int'(vram[addr + 8]);
        if (((attr / 64) % 2) == 0) begin
            lo = rev8(lo);
            hi = rev8(hi);
        end
        rec = 27'(lo * 524288 + hi * 2048 + x * 8 + (attr % 4) * 2 + ((attr / 32) % 2));
    endfunction

    // Observe outputs and play the VRAM responder (delays taken from dq).
    task automatic sample();
        int d;
        if (o_load != 4'd0) begin
            chk("load_strobe", 32'(o_load), 32'hF);
            act_loads.push_back(o_load_data);
        end
        if (o_done) done_cnt++;
        if (just_acked) chk("req_gap", 32'(o_vram_req), 32'd0);
        just_acked = 1'b0;
        if (o_vram_req) begin
            if (wcnt == 0) held = int'(o_vram_addr);
            else chk("req_hold", 32'(o_vram_addr), 32'(held));
            d = (dq.size() > 0) ? dq[0] : 0;
            if (wcnt >= d) begin
                i_vram_ack  = 1'b1;
                i_vram_data = vram[o_vram_addr];
                act_addrs.push_back(int'(o_vram_addr));
                if (dq.size() > 0) void'(dq.pop_front());
                wcnt = 0;
                just_acked = 1'b1;
            end else begin
                i_vram_ack  = 1'b0;
                i_vram_data = 8'($urandom);
                wcnt++;
            end
        end else begin
            wcnt        = 0;
            i_vram_ack  = 1'($urandom_range(0, 1));
            i_vram_data = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_cycle = (i_cycle == 9'd340) ? 9'd0 : i_cycle + 9'd1;
        sample();
    endtask

    task automatic prep_seq();
        logic [26:0] rec;
        int a;
        bit full;
        exp_loads.delete(); exp_addrs.delete(); dq.delete();
        act_loads.delete(); act_addrs.delete();
        done_cnt = 0; wcnt = 0; just_acked = 1'b0; seq_len = 0;
        for (int s = 0; s < 8; s++) begin
            model_slot(s, rec, a, full);
            exp_loads.push_back(rec);
            if (full) begin
                exp_addrs.push_back(a);
                exp_addrs.push_back(a + 8);
                dq.push_back(dlo[s]);
                dq.push_back(dhi[s]);
                seq_len += 9 + dlo[s] + dhi[s];
            end else begin
                seq_len += 5;
            end
        end
        i_rendering = 1'b1;
        i_cycle = 9'd250;
        repeat (7) tick();
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("overrun_clear_at_start", 32'(o_overrun), 32'd0);
    endtask

    task automatic run_seq();
        int n = 0;
        prep_seq();
        while (done_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        chk("done_within_budget", 32'(done_cnt > 0), 32'd1);
        repeat (4) tick();
        chk("n_loads", 32'(act_loads.size()), 32'd8);
        for (int i = 0; i < act_loads.size() && i < 8; i++)
            chk($sformatf("load_data_slot%0d", i), 32'(act_loads[i]), 32'(exp_loads[i]));
        chk("n_fetches", 32'(act_addrs.size()), 32'(exp_addrs.size()));
        for (int i = 0; i < act_addrs.size() && i < exp_addrs.size(); i++)
            chk($sformatf("fetch_addr%0d", i), 32'(act_addrs[i]), 32'(exp_addrs[i]));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("overrun", 32'(o_overrun), (seq_len >= 64) ? 32'd1 : 32'd0);
        chk("busy_end", 32'(o_busy), 32'd0);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 32; i++) tmp[i] = ((i % 4) == 0) ? 8'hFF : 8'h00;
        for (int s = 0; s < 8; s++) begin dlo[s] = 0; dhi[s] = 0; end
    endtask

    task automatic random_slots(input bit allow_empty);
        for (int s = 0; s < 8; s++) begin
            if (allow_empty && $urandom_range(0, 3) == 0) tmp[s*4] = 8'hFF;
            else tmp[s*4] = 8'(i_obj_size ? $urandom_range(0, 15) : $urandom_range(0, 7));
            tmp[s*4+1] = 8'($urandom);
            tmp[s*4+2] = 8'($urandom);
            tmp[s*4+3] = 8'($urandom);
            dlo[s] = 0;
            dhi[s] = 0;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        clear_slots();
        i_rst_n = 1'b0; i_rendering = 1'b0; i_cycle = 9'd0;
        i_obj_size = 1'b0; i_spr_table = 1'b0;
        i_vram_ack = 1'b0; i_vram_data = 8'd0;
        done_cnt = 0; wcnt = 0; held = 0; just_acked = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tmp_addr", 32'(o_tmp_addr), 32'd0);
        chk("rst_req", 32'(o_vram_req), 32'd0);
        chk("rst_vram_addr", 32'(o_vram_addr), 32'd0);
        chk("rst_load", 32'(o_load), 32'd0);
        chk("rst_load_data", 32'(o_load_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        @(negedge clk) i_rst_n = 1'b1;
        tick();

        // Directed vector table: slot 0 populated, other slots empty
        vt[0] = '{8'h03, 8'h42, 8'h00, 8'h10, 1'b0, 1'b1, 8'h80, 8'h03, 2'd2, 13'h1423, 8'h01, 8'hC0, 8'h10, 2'd0, 1'b0};
        vt[1] = '{8'h02, 8'h43, 8'hC1, 8'h20, 1'b1, 1'b0, 8'h80, 8'h0F, 2'd2, 13'h1435, 8'h80, 8'h0F, 8'h20, 2'd1, 1'b0};
        vt[2] = '{8'h05, 8'h00, 8'hA2, 8'h77, 1'b0, 1'b0, 8'hF0, 8'h12, 2'd2, 13'h0002, 8'h0F, 8'h48, 8'h77, 2'd2, 1'b1};
        vt[3] = '{8'h09, 8'hFE, 8'h03, 8'hF8, 1'b1, 1'b1, 8'h01, 8'hAA, 2'd2, 13'h0FF1, 8'h80, 8'h55, 8'hF8, 2'd3, 1'b0};
        vt[4] = '{8'h00, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 8'h3C, 8'hC3, 2'd2, 13'h1017, 8'h3C, 8'hC3, 8'h00, 2'd0, 1'b0};
        vt[5] = '{8'hFF, 8'h55, 8'hFF, 8'h99, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 13'h0000, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            clear_slots();
            tmp[0] = vt[k].y; tmp[1] = vt[k].tile; tmp[2] = vt[k].attr; tmp[3] = vt[k].x;
            i_obj_size = vt[k].sz;
            i_spr_table = vt[k].tbl;
            if (vt[k].nf == 2'd2) begin
                vram[vt[k].alo] = vt[k].lo;
                vram[vt[k].alo + 13'd8] = vt[k].hi;
            end
            run_seq();
            chk($sformatf("vec%0d_load", k), (act_loads.size() > 0) ? 32'(act_loads[0]) : 32'hDEADBEEF,
                32'({vt[k].plo, vt[k].phi, vt[k].ex, vt[k].pal, vt[k].prio}));
            chk($sformatf("vec%0d_nfetch", k), 32'(act_addrs.size()), 32'(vt[k].nf));
            if (act_addrs.size() >= 2) begin
                chk($sformatf("vec%0d_addr_lo", k), 32'(act_addrs[0]), 32'(vt[k].alo));
                chk($sformatf("vec%0d_addr_hi", k), 32'(act_addrs[1]), 32'(vt[k].alo) + 32'd8);
            end
        end

        // All 8 slots full, 1-cycle ack at 1x clock: deadline is missed
        i_obj_size = 1'b0; i_spr_table = 1'b1;
        random_slots(1'b0);
        run_seq();

        // Slots 3..7 empty; overrun from previous run clears at start
        random_slots(1'b0);
        for (int s = 3; s < 8; s++) tmp[s*4] = 8'hFF;
        run_seq();

        // Stalled hi-plane ack on slot 2
        i_obj_size = 1'b1;
        random_slots(1'b0);
        dhi[2] = 5;
        run_seq();

        // Abort mid FETCH_LO of slot 4
        i_obj_size = 1'b0;
        random_slots(1'b0);
        dlo[4] = 3;
        prep_seq();
        n = 0;
        while (!(act_loads.size() == 4 && o_vram_req) && n < 200) begin
            tick();
            n++;
        end
        chk("abort_reached_slot4", 32'(n < 200), 32'd1);
        i_rendering = 1'b0;
        tick();
        chk("abort_req_dropped", 32'(o_vram_req), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        repeat (30) tick();
        chk("abort_n_loads", 32'(act_loads.size()), 32'd4);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        for (int i = 0; i < act_loads.size() && i < 4; i++)
            chk($sformatf("abort_load%0d", i), 32'(act_loads[i]), 32'(exp_loads[i]));
        i_rendering = 1'b1;

        // Asynchronous reset during the third LOAD
        random_slots(1'b1);
        prep_seq();
        n = 0;
        while (!(act_loads.size() == 3 && o_load != 4'd0) && n < 300) begin
            tick();
            n++;
        end
        chk("reset_reached_load", 32'(n < 300), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("areset_load", 32'(o_load), 32'd0);
        chk("areset_busy", 32'(o_busy), 32'd0);
        chk("areset_req", 32'(o_vram_req), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) i_rst_n = 1'b1;
        tick();
        random_slots(1'b1);
        run_seq();

        // Randomized scanlines against the model
        for (int r = 0; r < 6; r++) begin
            i_obj_size = 1'($urandom_range(0, 1));
            i_spr_table = 1'($urandom_range(0, 1));
            random_slots(1'b1);
            for (int s = 0; s < 8; s++) begin
                dlo[s] = $urandom_range(0, 4);
                dhi[s] = $urandom_range(0, 4);
            end
            run_seq();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
